// File: rtl/ap_det_pkg.sv
// ap_det_pkg: shared types for the arithmetic-progression stream detector
package ap_det_pkg;
   typedef enum logic [1:0] {EMPTY, ONE, RUN} ap_state_e;
endpackage

// File: rtl/ap_stream_detector.sv
// ap_stream_detector: flags when the last LEN accepted samples share one modular difference
module ap_stream_detector
   import ap_det_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN = 7,
   localparam int RUN_W = $clog2(LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             nz_mode,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic             is_ap,
   output logic [WIDTH-1:0] diff,
   output logic [RUN_W-1:0] run_len
);
   localparam logic [RUN_W-1:0] LEN_R = RUN_W'(LEN);
   localparam logic [RUN_W-1:0] RUN1 = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN2 = RUN_W'(2);
   ap_state_e state, state_n;
   logic [WIDTH-1:0] prev, prev_n, diff_n, d;
   logic [RUN_W-1:0] run_n;
   logic valid_n, ap_n, zero_brk;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= EMPTY;
         prev      <= '0;
         diff      <= '0;
         run_len   <= '0;
         out_valid <= 1'b0;
         is_ap     <= 1'b0;
      end else begin
         state     <= state_n;
         prev      <= prev_n;
         diff      <= diff_n;
         run_len   <= run_n;
         out_valid <= valid_n;
         is_ap     <= ap_n;
      end
   // a mismatching difference restarts at run=2: the previous sample opens the new run
   always_comb begin
      d        = in_data - prev;
      zero_brk = nz_mode && d == '0;
      state_n  = state;
      prev_n   = prev;
      diff_n   = diff;
      run_n    = run_len;
      valid_n  = 1'b0;
      ap_n     = is_ap;
      if (clear) begin
         state_n = EMPTY;
         diff_n  = '0;
         run_n   = '0;
         ap_n    = 1'b0;
      end else if (in_valid) begin
         valid_n = 1'b1;
         prev_n  = in_data;
         case (state)
            ONE: begin
               state_n = zero_brk ? ONE : RUN;
               run_n   = zero_brk ? RUN1 : RUN2;
               diff_n  = zero_brk ? diff : d;
            end
            RUN: begin
               state_n = zero_brk ? ONE : RUN;
               diff_n  = (zero_brk || d == diff) ? diff : d;
               run_n   = zero_brk ? RUN1 :
                         d != diff ? RUN2 :
                         run_len == LEN_R ? LEN_R : run_len + RUN1;
            end
            default: begin
               state_n = ONE;
               run_n   = RUN1;
            end
         endcase
         ap_n = run_n == LEN_R;
      end
   end
endmodule
